// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480 VGA timing constants, decoder FSM state and CRC-16 helper
package vga_timing_pkg;

    localparam int H_TOTAL     = 800;
    localparam int V_TOTAL     = 521;
    localparam int H_PULSE     = 96;
    localparam int H_BP        = 144;
    localparam int H_FP        = 784;
    localparam int V_BP        = 31;
    localparam int V_FP        = 511;
    localparam int LOCK_FRAMES = 2;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } dec_state_t;

    // MSB-first CRC-16-CCITT update over one byte
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i])
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - input register stage and sync edge strobes
module vga_sync_edge (
    input  logic       dclk,
    input  logic       clr,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [7:0] rgb_in,
    output logic [7:0] rgb_s1,
    output logic       hfall,
    output logic       hrise,
    output logic       vfall
);

    logic hs1, vs1, hs2, vs2;

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            hs1    <= 1'b0;
            vs1    <= 1'b0;
            hs2    <= 1'b0;
            vs2    <= 1'b0;
            rgb_s1 <= 8'd0;
        end else begin
            hs1    <= hsync_in;
            vs1    <= vsync_in;
            rgb_s1 <= rgb_in;
            hs2    <= hs1;
            vs2    <= vs1;
        end
    end

    assign hfall = hs2 & ~hs1;
    assign hrise = ~hs2 & hs1;
    assign vfall = vs2 & ~vs1;

endmodule

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA sync decoder: position recovery, timing lock and error reporting
// Optional per-frame CRC-16 of active pixels when VGA_DEC_CRC_EN is defined.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int H_PULSE     = vga_timing_pkg::H_PULSE,
    parameter int H_BP        = vga_timing_pkg::H_BP,
    parameter int H_FP        = vga_timing_pkg::H_FP,
    parameter int V_BP        = vga_timing_pkg::V_BP,
    parameter int V_FP        = vga_timing_pkg::V_FP,
    parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
    input  logic        dclk,
    input  logic        clr,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [7:0]  rgb_in,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_valid,
    output logic [7:0]  pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err,
    output logic [7:0]  err_count,
    output logic [15:0] frame_crc,
    output logic        crc_valid
);

    localparam logic [9:0] CNT_MAX   = 10'd1023;
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_PW      = 10'(H_PULSE);
    localparam logic [9:0] HB        = 10'(H_BP);
    localparam logic [9:0] HF        = 10'(H_FP);
    localparam logic [9:0] VB        = 10'(V_BP);
    localparam logic [9:0] VF        = 10'(V_FP);
    localparam logic [7:0] GOOD_LOCK = 8'(LOCK_FRAMES);

    logic [7:0] rgb_s1;
    logic       hfall, hrise, vfall;
    logic [9:0] hcnt, vcnt, hpos, vpos;
    logic       aligned, timing_err, valid_next, start_next;
    logic [7:0] good;
    dec_state_t state;

    vga_sync_edge u_edge (
        .dclk     (dclk),
        .clr      (clr),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .rgb_in   (rgb_in),
        .rgb_s1   (rgb_s1),
        .hfall    (hfall),
        .hrise    (hrise),
        .vfall    (vfall)
    );

    always_comb begin
        hpos = hfall ? 10'd0 : ((hcnt == CNT_MAX) ? CNT_MAX : hcnt + 10'd1);
        if (vfall && hfall)
            vpos = 10'd0;
        else if (hfall)
            vpos = (vcnt == CNT_MAX) ? CNT_MAX : vcnt + 10'd1;
        else
            vpos = vcnt;

        aligned    = vfall & hfall;
        valid_next = locked & (hpos >= HB) & (hpos < HF) & (vpos >= VB) & (vpos < VF);
        start_next = valid_next & (hpos == HB) & (vpos == VB);

        // Timing is only judged once an aligned frame start has been seen
        timing_err = (state != SEARCH) &
                     ((hfall & (hcnt != H_LAST)) |
                      (hrise & (hpos != H_PW)) |
                      (aligned & (vcnt != V_LAST)) |
                      (vfall & ~hfall) |
                      (hcnt == CNT_MAX));
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            hcnt        <= 10'd0;
            vcnt        <= 10'd0;
            pix_x       <= 10'd0;
            pix_y       <= 10'd0;
            pix_rgb     <= 8'd0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcnt        <= hpos;
            vcnt        <= vpos;
            pix_valid   <= valid_next;
            frame_start <= start_next;
            if (valid_next) begin
                pix_x   <= hpos - HB;
                pix_y   <= vpos - VB;
                pix_rgb <= rgb_s1;
            end
        end
    end

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state     <= SEARCH;
            good      <= 8'd0;
            locked    <= 1'b0;
            sync_err  <= 1'b0;
            err_count <= 8'd0;
        end else begin
            sync_err <= 1'b0;
            if (timing_err) begin
                sync_err <= 1'b1;
                if (err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
                state  <= SEARCH;
                locked <= 1'b0;
                good   <= 8'd0;
            end else begin
                case (state)
                    SEARCH: begin
                        locked <= 1'b0;
                        if (aligned) begin
                            state <= VERIFY;
                            good  <= 8'd0;
                        end
                    end
                    VERIFY: begin
                        locked <= 1'b0;
                        if (aligned) begin
                            good <= good + 8'd1;
                            if (good + 8'd1 == GOOD_LOCK) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED:  locked <= 1'b1;
                    default: state  <= SEARCH;
                endcase
            end
        end
    end

`ifdef VGA_DEC_CRC_EN
    logic [15:0] crc_acc;

    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            crc_acc   <= CRC_INIT;
            frame_crc <= 16'd0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            if (valid_next)
                crc_acc <= crc16_byte(start_next ? CRC_INIT : crc_acc, rgb_s1);
            // hpos is zero only on the hfall cycle, so this fires once per frame
            if (vpos == VF && hpos == 10'd0) begin
                frame_crc <= crc_acc;
                crc_valid <= 1'b1;
            end
        end
    end
`else
    assign frame_crc = 16'd0;
    assign crc_valid = 1'b0;
`endif

endmodule
